// File: rtl/alu_decode_stage_pkg.sv
// Shared ALU op encodings, RV32 opcode constants and decode-stage types.
package alu_decode_stage_pkg;

    localparam int unsigned ALU_OP_W = 5;
    localparam int unsigned INST_W   = 32;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_BEQ    = 5'b00000;
    localparam alu_op_t ALU_BNE    = 5'b00001;
    localparam alu_op_t ALU_LT     = 5'b00010;
    localparam alu_op_t ALU_LTU    = 5'b00011;
    localparam alu_op_t ALU_GE     = 5'b00100;
    localparam alu_op_t ALU_GEU    = 5'b00101;
    localparam alu_op_t ALU_ADD    = 5'b00110;
    localparam alu_op_t ALU_LUI    = 5'b00111;
    localparam alu_op_t ALU_XOR    = 5'b01000;
    localparam alu_op_t ALU_OR     = 5'b01001;
    localparam alu_op_t ALU_AND    = 5'b01010;
    localparam alu_op_t ALU_SLL    = 5'b01011;
    localparam alu_op_t ALU_SRA    = 5'b01100;
    localparam alu_op_t ALU_SRL    = 5'b01101;
    localparam alu_op_t ALU_SUB    = 5'b01110;
    localparam alu_op_t ALU_NOP    = 5'b01111;
    localparam alu_op_t ALU_MUL    = 5'b10000;
    localparam alu_op_t ALU_MULH   = 5'b10001;
    localparam alu_op_t ALU_MULHSU = 5'b10010;
    localparam alu_op_t ALU_MULHU  = 5'b10011;
    localparam alu_op_t ALU_DIV    = 5'b10100;
    localparam alu_op_t ALU_DIVU   = 5'b10101;
    localparam alu_op_t ALU_REM    = 5'b10110;
    localparam alu_op_t ALU_REMU   = 5'b10111;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    typedef struct packed {
        alu_op_t op;
        logic    illegal;
        logic    muldiv;
    } dec_t;

    localparam dec_t DEC_NOP = '{op: ALU_NOP, illegal: 1'b0, muldiv: 1'b0};

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // Shared OP-IMM / OP(f7=0) map; returns {illegal, op}.
    function automatic logic [ALU_OP_W:0] base_map(input logic [2:0] f3, input logic [6:0] f7);
        logic [ALU_OP_W:0] r;
        r = {1'b0, ALU_NOP};
        unique case (f3)
            3'b000: r = {1'b0, ALU_ADD};
            3'b010: r = {1'b0, ALU_LT};
            3'b011: r = {1'b0, ALU_LTU};
            3'b100: r = {1'b0, ALU_XOR};
            3'b110: r = {1'b0, ALU_OR};
            3'b111: r = {1'b0, ALU_AND};
            3'b001: r = (f7 == F7_ZERO) ? {1'b0, ALU_SLL} : {1'b1, ALU_NOP};
            3'b101: begin
                if (f7 == F7_ALT)       r = {1'b0, ALU_SRA};
                else if (f7 == F7_ZERO) r = {1'b0, ALU_SRL};
                else                    r = {1'b1, ALU_NOP};
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// Instruction-in / decoded-op-out handshake bundle of the decode stage.
interface alu_decode_stage_if #(
    parameter int unsigned OP_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] out_aluop;
    logic            out_illegal;
    logic            out_muldiv;

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_aluop, out_illegal, out_muldiv
    );

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_aluop, out_illegal, out_muldiv
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32I(+M) instruction to ALU op / illegal / muldiv decode.
module alu_op_decode
    import alu_decode_stage_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [INST_W-1:0] inst,
    output dec_t              dec
);

    logic [6:0]        opcode;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [ALU_OP_W:0] base;
    logic              unused_bits;

    assign opcode      = inst[6:0];
    assign f3          = inst[14:12];
    assign f7          = inst[31:25];
    assign base        = base_map(f3, f7);
    assign unused_bits = ^{inst[24:15], inst[11:7]};

    always_comb begin
        dec = DEC_NOP;
        unique case (opcode)
            OPC_BRANCH: begin
                unique case (f3)
                    3'b000:  dec.op = ALU_BEQ;
                    3'b001:  dec.op = ALU_BNE;
                    3'b100:  dec.op = ALU_LT;
                    3'b101:  dec.op = ALU_GE;
                    3'b110:  dec.op = ALU_LTU;
                    3'b111:  dec.op = ALU_GEU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_AUIPC: dec.op = ALU_ADD;
            OPC_LUI:                        dec.op = ALU_LUI;
            OPC_JAL, OPC_JALR:              dec.op = ALU_NOP;
            OPC_OP_IMM: {dec.illegal, dec.op} = base;
            OPC_OP: begin
                if (f7 == F7_ZERO) begin
                    {dec.illegal, dec.op} = base;
                end else if (f7 == F7_ALT) begin
                    if (f3 == 3'b000)      dec.op = ALU_SUB;
                    else if (f3 == 3'b101) dec.op = ALU_SRA;
                    else                   dec.illegal = 1'b1;
                end else if (ENABLE_M && (f7 == F7_MULD)) begin
                    dec.op     = {2'b10, f3};
                    dec.muldiv = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        // Illegal words always present as a NOP with no unit select.
        if (dec.illegal) begin
            dec.op     = ALU_NOP;
            dec.muldiv = 1'b0;
        end
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage: decoder feeding a 2-entry skid buffer, plus illegal-instruction tracking.
module alu_decode_stage
    import alu_decode_stage_pkg::*;
#(
    parameter bit          ENABLE_M = 1'b0,
    parameter int unsigned OP_W     = 5,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_decode_stage_if.slave bus,
    input  logic             illegal_clr,
    output logic             illegal_seen,
    output logic [CNT_W-1:0] illegal_cnt
);

    if (OP_W < ALU_OP_W) begin : g_op_w_check
        $error("alu_decode_stage: OP_W must be at least 5");
    end

    skid_state_e      state_q, state_n;
    dec_t             dec, a_q, a_n, b_q, b_n;
    logic             in_ready_q, in_ready_n;
    logic             out_valid_q, out_valid_n;
    logic             seen_q, seen_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             accept, drain;

    alu_op_decode #(.ENABLE_M(ENABLE_M)) u_decode (
        .inst (bus.in_inst),
        .dec  (dec)
    );

    assign accept = bus.in_valid && in_ready_q;
    assign drain  = out_valid_q && bus.out_ready;

    // Slot A is the output register, slot B the skid register.
    always_comb begin
        state_n     = state_q;
        a_n         = a_q;
        b_n         = b_q;
        seen_n      = seen_q;
        cnt_n       = cnt_q;
        unique case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    a_n     = dec;
                    state_n = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept && drain) begin
                    a_n = dec;
                end else if (accept) begin
                    b_n     = dec;
                    state_n = SKID_TWO;
                end else if (drain) begin
                    state_n = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (drain) begin
                    a_n     = b_q;
                    state_n = SKID_ONE;
                end
            end
            default: state_n = SKID_EMPTY;
        endcase
        out_valid_n = (state_n != SKID_EMPTY);
        in_ready_n  = (state_n != SKID_TWO);

        // Clear takes priority over a simultaneous illegal accept.
        if (illegal_clr) begin
            seen_n = 1'b0;
            cnt_n  = '0;
        end else if (accept && dec.illegal) begin
            seen_n = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) cnt_n = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= SKID_EMPTY;
            a_q         <= DEC_NOP;
            b_q         <= DEC_NOP;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            seen_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_n;
            a_q         <= a_n;
            b_q         <= b_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
            seen_q      <= seen_n;
            cnt_q       <= cnt_n;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_aluop   = OP_W'(a_q.op);
    assign bus.out_illegal = a_q.illegal;
    assign bus.out_muldiv  = a_q.muldiv;
    assign illegal_seen    = seen_q;
    assign illegal_cnt     = cnt_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench: M-enabled/16-bit-counter and M-disabled/2-bit-counter stages share one stimulus stream.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        out_ready;
    logic        illegal_clr;

    logic        seen_m, seen_n;
    logic [15:0] cnt_m;
    logic [1:0]  cnt_n;

    int checks = 0;
    int errors = 0;

    alu_decode_stage_if #(.OP_W(5)) if_m ();
    alu_decode_stage_if #(.OP_W(5)) if_n ();

    assign if_m.in_valid  = in_valid;
    assign if_m.in_inst   = in_inst;
    assign if_m.out_ready = out_ready;
    assign if_n.in_valid  = in_valid;
    assign if_n.in_inst   = in_inst;
    assign if_n.out_ready = out_ready;

    alu_decode_stage #(.ENABLE_M(1'b1), .OP_W(5), .CNT_W(16)) dut_m (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (if_m.slave),
        .illegal_clr  (illegal_clr),
        .illegal_seen (seen_m),
        .illegal_cnt  (cnt_m)
    );

    alu_decode_stage #(.ENABLE_M(1'b0), .OP_W(5), .CNT_W(2)) dut_n (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (if_n.slave),
        .illegal_clr  (illegal_clr),
        .illegal_seen (seen_n),
        .illegal_cnt  (cnt_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADD  = 32'h003100B3;
    localparam logic [31:0] I_SUB  = 32'h403100B3;
    localparam logic [31:0] I_SRAI = 32'h4050D093;
    localparam logic [31:0] I_OR   = 32'h003160B3;
    localparam logic [31:0] I_DIVU = 32'h0231D0B3;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    logic [31:0] tv_inst [8];
    logic [4:0]  tv_op   [8];
    logic        tv_ill  [8];
    logic        tv_md   [8];

    initial begin
        tv_inst[0] = 32'h000000B7; tv_op[0] = 5'h07; tv_ill[0] = 1'b0; tv_md[0] = 1'b0;
        tv_inst[1] = 32'h0000006F; tv_op[1] = 5'h0F; tv_ill[1] = 1'b0; tv_md[1] = 1'b0;
        tv_inst[2] = 32'h00012083; tv_op[2] = 5'h06; tv_ill[2] = 1'b0; tv_md[2] = 1'b0;
        tv_inst[3] = 32'h40011093; tv_op[3] = 5'h0F; tv_ill[3] = 1'b1; tv_md[3] = 1'b0;
        tv_inst[4] = 32'h00000000; tv_op[4] = 5'h0F; tv_ill[4] = 1'b1; tv_md[4] = 1'b0;
        tv_inst[5] = 32'h0FF17093; tv_op[5] = 5'h0A; tv_ill[5] = 1'b0; tv_md[5] = 1'b0;
        tv_inst[6] = 32'h023100B3; tv_op[6] = 5'h10; tv_ill[6] = 1'b0; tv_md[6] = 1'b1;
        tv_inst[7] = 32'h0020E063; tv_op[7] = 5'h03; tv_ill[7] = 1'b0; tv_md[7] = 1'b0;

        rst_n = 1'b0; in_valid = 1'b1; in_inst = I_ADD; out_ready = 1'b1; illegal_clr = 1'b0;
        repeat (3) step();
        check("rst_out_valid", 32'(if_m.out_valid), 32'd0);
        check("rst_in_ready", 32'(if_m.in_ready), 32'd0);
        check("rst_aluop", 32'(if_m.out_aluop), 32'h0F);
        check("rst_illegal", 32'(if_m.out_illegal), 32'd0);
        check("rst_muldiv", 32'(if_m.out_muldiv), 32'd0);
        check("rst_cnt", 32'(cnt_m), 32'd0);
        check("rst_seen", 32'(seen_m), 32'd0);

        rst_n = 1'b1; in_valid = 1'b0;
        step();
        check("post_rst_in_ready", 32'(if_m.in_ready), 32'd1);
        check("post_rst_out_valid", 32'(if_m.out_valid), 32'd0);

        // Streaming with no backpressure, one op per cycle.
        in_valid = 1'b1; in_inst = I_ADD;
        step();
        check("stream_add_valid", 32'(if_m.out_valid), 32'd1);
        check("stream_add", 32'(if_m.out_aluop), 32'h06);
        in_inst = I_SUB;
        step();
        check("stream_sub", 32'(if_m.out_aluop), 32'h0E);
        check("stream_in_ready", 32'(if_m.in_ready), 32'd1);
        in_inst = I_SRAI;
        step();
        check("stream_srai", 32'(if_m.out_aluop), 32'h0C);
        check("stream_srai_ill", 32'(if_m.out_illegal), 32'd0);
        in_valid = 1'b0;
        step();
        check("stream_drained", 32'(if_m.out_valid), 32'd0);

        // Backpressure: three ops offered while execute stalls for four cycles.
        out_ready = 1'b0; in_valid = 1'b1; in_inst = I_ADD;
        step();
        check("bp_first_ready", 32'(if_m.in_ready), 32'd1);
        check("bp_first_op", 32'(if_m.out_aluop), 32'h06);
        in_inst = I_SUB;
        step();
        check("bp_full_ready", 32'(if_m.in_ready), 32'd0);
        check("bp_hold_op1", 32'(if_m.out_aluop), 32'h06);
        in_inst = I_OR;
        step();
        check("bp_hold_op2", 32'(if_m.out_aluop), 32'h06);
        check("bp_still_full", 32'(if_m.in_ready), 32'd0);
        step();
        check("bp_hold_valid", 32'(if_m.out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        check("bp_second", 32'(if_m.out_aluop), 32'h0E);
        check("bp_ready_back", 32'(if_m.in_ready), 32'd1);
        step();
        check("bp_third", 32'(if_m.out_aluop), 32'h09);
        in_valid = 1'b0;
        step();
        check("bp_empty", 32'(if_m.out_valid), 32'd0);

        // M extension enabled vs disabled.
        in_valid = 1'b1; in_inst = I_DIVU;
        step();
        check("m_divu_op", 32'(if_m.out_aluop), 32'h15);
        check("m_divu_md", 32'(if_m.out_muldiv), 32'd1);
        check("m_divu_ill", 32'(if_m.out_illegal), 32'd0);
        check("m_seen_clear", 32'(seen_m), 32'd0);
        check("nom_divu_op", 32'(if_n.out_aluop), 32'h0F);
        check("nom_divu_ill", 32'(if_n.out_illegal), 32'd1);
        check("nom_divu_md", 32'(if_n.out_muldiv), 32'd0);
        check("nom_cnt1", 32'(cnt_n), 32'd1);

        // Illegal tracking and saturation of the 2-bit counter.
        in_inst = I_BAD;
        repeat (3) step();
        check("ill_op", 32'(if_m.out_aluop), 32'h0F);
        check("ill_flag", 32'(if_m.out_illegal), 32'd1);
        check("ill_seen", 32'(seen_m), 32'd1);
        check("ill_cnt3", 32'(cnt_m), 32'd3);
        check("nom_cnt_sat_a", 32'(cnt_n), 32'd3);
        repeat (2) step();
        check("ill_cnt5", 32'(cnt_m), 32'd5);
        check("nom_cnt_sat_b", 32'(cnt_n), 32'd3);
        illegal_clr = 1'b1;
        step();
        illegal_clr = 1'b0;
        check("clr_cnt", 32'(cnt_m), 32'd0);
        check("clr_seen", 32'(seen_m), 32'd0);
        check("nom_clr_cnt", 32'(cnt_n), 32'd0);

        // Branch decode boundaries.
        in_inst = 32'h0020A063;
        step();
        check("br_f3_010_ill", 32'(if_m.out_illegal), 32'd1);
        check("br_f3_010_op", 32'(if_m.out_aluop), 32'h0F);
        check("br_cnt1", 32'(cnt_m), 32'd1);
        in_inst = 32'h0020F063;
        step();
        check("bgeu_op", 32'(if_m.out_aluop), 32'h05);
        check("bgeu_ill", 32'(if_m.out_illegal), 32'd0);

        // Mixed decode vectors, streamed back to back.
        for (int i = 0; i < 8; i++) begin
            in_inst = tv_inst[i];
            step();
            check($sformatf("vec%0d_op", i), 32'(if_m.out_aluop), 32'(tv_op[i]));
            check($sformatf("vec%0d_ill", i), 32'(if_m.out_illegal), 32'(tv_ill[i]));
            check($sformatf("vec%0d_md", i), 32'(if_m.out_muldiv), 32'(tv_md[i]));
        end

        // Reset while both slots hold ops drops them.
        out_ready = 1'b0; in_inst = I_ADD;
        repeat (2) step();
        check("mid_full", 32'(if_m.in_ready), 32'd0);
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", 32'(if_m.out_valid), 32'd0);
        check("mid_rst_aluop", 32'(if_m.out_aluop), 32'h0F);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("mid_post_ready", 32'(if_m.in_ready), 32'd1);
        check("mid_post_valid", 32'(if_m.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
